// File: rtl/reg_operand_fetch.sv
// reg_operand_fetch: small register bank with a D/En write port and a
// two-cycle operand fetch (A, then B) presented to the ALU over VALID/ACK.
//
// Handshake: VALID is high exactly while the FSM sits in HOLD, and OPA/OPB are
// frozen for that whole window. A transfer completes on a rising CLK edge where
// VALID=1 and ACK=1. ACK is ignored outside HOLD, and REQ is only accepted in
// IDLE or together with ACK in HOLD. A REQ that arrives at any other time is
// dropped, not queued.
//
// The whole FSM state is the single register r_state, so checkers can be bound
// to it directly.
module reg_operand_fetch #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic             CLK,
   input  logic             CLR,
   input  logic [WIDTH-1:0] D,
   input  logic [AW-1:0]    WA,
   input  logic             En,
   input  logic             REQ,
   input  logic [AW-1:0]    RA_A,
   input  logic [AW-1:0]    RA_B,
   input  logic             ACK,
   output logic             BUSY,
   output logic             VALID,
   output logic [WIDTH-1:0] OPA,
   output logic [WIDTH-1:0] OPB
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_FETCH_A = 2'd1,
      S_FETCH_B = 2'd2,
      S_HOLD    = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic             w_latch_addr;
   logic             w_load_a;
   logic             w_load_b;

   logic [WIDTH-1:0] r_bank [DEPTH];
   logic [AW-1:0]    r_addr_a;
   logic [AW-1:0]    r_addr_b;
   logic [WIDTH-1:0] r_opa;
   logic [WIDTH-1:0] r_opb;
   logic [WIDTH-1:0] w_fwd_a;
   logic [WIDTH-1:0] w_fwd_b;

   // A write landing on the same edge as a fetch is forwarded, so the operand
   // always matches what the bank holds after that edge.
   assign w_fwd_a = (En && (WA == r_addr_a)) ? D : r_bank[r_addr_a];
   assign w_fwd_b = (En && (WA == r_addr_b)) ? D : r_bank[r_addr_b];

   // Bank writes are independent of the FSM and are accepted in every state.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_bank[i] <= '0;
         end
      end else if (En) begin
         r_bank[WA] <= D;
      end
   end

   // State register.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic and the strobes that load the address and operand registers.
   always_comb begin
      w_next_state = r_state;
      w_latch_addr = 1'b0;
      w_load_a     = 1'b0;
      w_load_b     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (REQ) begin
               w_latch_addr = 1'b1;
               w_next_state = S_FETCH_A;
            end
         end
         S_FETCH_A: begin
            w_load_a     = 1'b1;
            w_next_state = S_FETCH_B;
         end
         S_FETCH_B: begin
            w_load_b     = 1'b1;
            w_next_state = S_HOLD;
         end
         S_HOLD: begin
            if (ACK && REQ) begin
               w_latch_addr = 1'b1;
               w_next_state = S_FETCH_A;
            end else if (ACK) begin
               w_next_state = S_IDLE;
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // Latch the operand addresses when a request is accepted.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         r_addr_a <= '0;
         r_addr_b <= '0;
      end else if (w_latch_addr) begin
         r_addr_a <= RA_A;
         r_addr_b <= RA_B;
      end
   end

   // Operand snapshots: these registers load only in their fetch cycle, so later
   // writes to the bank never disturb a presented operand.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         r_opa <= '0;
         r_opb <= '0;
      end else begin
         if (w_load_a) begin
            r_opa <= w_fwd_a;
         end
         if (w_load_b) begin
            r_opb <= w_fwd_b;
         end
      end
   end

   assign OPA   = r_opa;
   assign OPB   = r_opb;
   assign VALID = (r_state == S_HOLD);
   assign BUSY  = (r_state != S_IDLE);

endmodule

// File: tb/tb_reg_operand_fetch.sv
// Directed testbench for reg_operand_fetch. When a request is issued, the main
// process pushes the expected {OPA,OPB} pair. A separate monitor pops one entry
// at the start of each VALID window and checks it on every HOLD cycle.
module tb_reg_operand_fetch;

   logic       CLK;
   logic       CLR;
   logic [7:0] D;
   logic [1:0] WA;
   logic       En;
   logic       REQ;
   logic [1:0] RA_A;
   logic [1:0] RA_B;
   logic       ACK;
   logic       BUSY;
   logic       VALID;
   logic [7:0] OPA;
   logic [7:0] OPB;

   logic [15:0] exp_q[$];
   logic [15:0] cur_exp;
   logic        prev_valid;
   int          total;
   int          bad;
   int          windows;
   int          pushes;

   reg_operand_fetch #(.WIDTH(8), .DEPTH(4), .AW(2)) dut (
      .CLK   (CLK),
      .CLR   (CLR),
      .D     (D),
      .WA    (WA),
      .En    (En),
      .REQ   (REQ),
      .RA_A  (RA_A),
      .RA_B  (RA_B),
      .ACK   (ACK),
      .BUSY  (BUSY),
      .VALID (VALID),
      .OPA   (OPA),
      .OPB   (OPB)
   );

   // Clock generation: period 10, rising edges at 5, 15, 25, ...
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: samples on the falling edge, away from the active edge.
   initial begin
      prev_valid = 1'b0;
      cur_exp    = '0;
      forever begin
         @(negedge CLK);
         if (CLR && VALID) begin
            if (!prev_valid) begin
               windows++;
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_valid: VALID window with empty queue at %0t", $time);
                  cur_exp = {OPA, OPB};
               end else begin
                  cur_exp = exp_q.pop_front();
               end
            end
            check("opa", {8'h00, OPA}, {8'h00, cur_exp[15:8]});
            check("opb", {8'h00, OPB}, {8'h00, cur_exp[7:0]});
         end
         prev_valid = CLR && VALID;
      end
   end

   // Driver tasks: inputs change 1 time unit after the rising edge.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
      En = 1'b1;
      WA = a;
      D  = d;
      tick();
      En = 1'b0;
   endtask

   task automatic request(input logic [1:0] a, input logic [1:0] b, input logic [15:0] exp);
      exp_q.push_back(exp);
      pushes++;
      REQ  = 1'b1;
      RA_A = a;
      RA_B = b;
      tick();
      REQ  = 1'b0;
   endtask

   task automatic wait_valid();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (VALID) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         total++;
         bad++;
         $display("FAIL valid_timeout: VALID not seen within 20 cycles at %0t", $time);
      end
   endtask

   task automatic ack_idle();
      ACK = 1'b1;
      tick();
      ACK = 1'b0;
      check("valid_after_ack", {15'd0, VALID}, 16'd0);
      check("busy_after_ack", {15'd0, BUSY}, 16'd0);
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      windows = 0;
      pushes = 0;
      CLR  = 1'b0;
      D    = '0;
      WA   = '0;
      En   = 1'b0;
      REQ  = 1'b0;
      RA_A = '0;
      RA_B = '0;
      ACK  = 1'b0;

      // Reset held for two cycles.
      tick();
      tick();
      check("rst_opa", {8'h00, OPA}, 16'd0);
      check("rst_opb", {8'h00, OPB}, 16'd0);
      check("rst_valid", {15'd0, VALID}, 16'd0);
      check("rst_busy", {15'd0, BUSY}, 16'd0);
      CLR = 1'b1;
      tick();

      // Latency: VALID rises after the third edge, counting the REQ edge.
      request(2'd0, 2'd0, 16'h0000);
      check("lat_k_valid", {15'd0, VALID}, 16'd0);
      check("lat_k_busy", {15'd0, BUSY}, 16'd1);
      tick();
      check("lat_k1_valid", {15'd0, VALID}, 16'd0);
      tick();
      check("lat_k2_valid", {15'd0, VALID}, 16'd1);
      ack_idle();

      // Basic fetch, held for 5 cycles without ACK.
      write_reg(2'd1, 8'h0A);
      write_reg(2'd2, 8'h01);
      request(2'd1, 2'd2, 16'h0A01);
      wait_valid();
      repeat (5) tick();
      check("hold_valid", {15'd0, VALID}, 16'd1);
      ack_idle();

      // Forwarding: write into bank[3] during the FETCH_A cycle.
      write_reg(2'd3, 8'h11);
      request(2'd3, 2'd3, 16'h5555);
      En = 1'b1;
      WA = 2'd3;
      D  = 8'h55;
      tick();
      En = 1'b0;
      wait_valid();
      ack_idle();

      // Snapshot: writes in HOLD leave OPA unchanged. A REQ without ACK is ignored.
      request(2'd1, 2'd2, 16'h0A01);
      wait_valid();
      write_reg(2'd1, 8'hFF);
      REQ  = 1'b1;
      RA_A = 2'd3;
      RA_B = 2'd3;
      tick();
      REQ  = 1'b0;
      tick();
      check("snap_still_hold", {15'd0, VALID}, 16'd1);

      // Back-to-back: ACK and REQ together go straight to FETCH_A.
      exp_q.push_back(16'h01FF);
      pushes++;
      ACK  = 1'b1;
      REQ  = 1'b1;
      RA_A = 2'd2;
      RA_B = 2'd1;
      tick();
      ACK  = 1'b0;
      REQ  = 1'b0;
      check("b2b_busy", {15'd0, BUSY}, 16'd1);
      check("b2b_valid", {15'd0, VALID}, 16'd0);
      tick();
      // Now in FETCH_B; this REQ pulse must be dropped.
      REQ  = 1'b1;
      RA_A = 2'd0;
      RA_B = 2'd0;
      tick();
      REQ  = 1'b0;
      check("b2b_hold", {15'd0, VALID}, 16'd1);
      ack_idle();
      repeat (4) tick();
      check("no_extra_window", {15'd0, VALID}, 16'd0);

      // A later fetch of A from entry 1 sees the new value.
      request(2'd1, 2'd3, 16'hFF55);
      wait_valid();
      ack_idle();

      // Async reset in the middle of FETCH_B.
      request(2'd2, 2'd1, 16'h01FF);
      void'(exp_q.pop_back());
      pushes--;
      tick();
      #2;
      CLR = 1'b0;
      #1;
      check("arst_valid", {15'd0, VALID}, 16'd0);
      check("arst_busy", {15'd0, BUSY}, 16'd0);
      check("arst_opa", {8'h00, OPA}, 16'd0);
      check("arst_opb", {8'h00, OPB}, 16'd0);
      tick();
      CLR = 1'b1;
      tick();
      request(2'd1, 2'd2, 16'h0000);
      wait_valid();
      ack_idle();

      repeat (3) tick();
      check("queue_empty", 16'(exp_q.size()), 16'd0);
      check("window_count", 16'(windows), 16'(pushes));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/reg_operand_fetch.md
Name: reg_operand_fetch

Overview:
- Read-side companion to the 8-bit register storage in the mini CPU datapath.
- Holds a small bank of 8-bit registers loaded through a D/En write port.
- On request, fetches two operands (A, then B) and presents them to the ALU.
- Uses a VALID/ACK handshake. Write-to-read forwarding keeps operands coherent with in-flight writes.

Parameters:
WIDTH, 8, data width of each register and operand
DEPTH, 4, number of registers in the bank
AW, 2, address width (log2 DEPTH)

Ports:
CLK  input  1  rising-edge clock
CLR  input  1  asynchronous active-low reset; 0 clears all state immediately
D  input  WIDTH  write data
WA  input  AW  write address
En  input  1  write enable; bank[WA] <= D on rising CLK edge
REQ  input  1  operand fetch request
RA_A  input  AW  operand A address, sampled with REQ
RA_B  input  AW  operand B address, sampled with REQ
ACK  input  1  consumer accepts OPA/OPB
BUSY  output  1  high whenever FSM not in IDLE
VALID  output  1  OPA/OPB valid
OPA  output  WIDTH  operand A
OPB  output  WIDTH  operand B

Behaviour:
- Reset (CLR=0, async):
  - All bank entries = 0; OPA = OPB = 0.
  - VALID = 0, BUSY = 0, state = IDLE.
  - Latched addresses = 0. Held in reset while CLR=0.
- Writes: independent of FSM; accepted in any state when En=1. Last write wins per edge.
- FSM states: IDLE, FETCH_A, FETCH_B, HOLD.
  - IDLE: when REQ=1 at the edge, latch RA_A/RA_B and go to FETCH_A. REQ=0 stays IDLE.
  - FETCH_A: OPA <= (En && WA==latched A) ? D : bank[latched A]; go to FETCH_B.
  - FETCH_B: OPB <= same forwarding rule with latched B; go to HOLD.
  - HOLD: VALID=1; OPA/OPB frozen.
    - ACK=0 stays HOLD.
    - ACK=1 and REQ=0 goes to IDLE; VALID low after that edge.
    - ACK=1 and REQ=1 latches new addresses and goes to FETCH_A (back-to-back).
- Latency: REQ sampled at edge k, then VALID=1 after edge k+2. Minimum request-to-request period is 3 cycles.
- VALID is a registered output: exactly (state==HOLD). BUSY = (state!=IDLE).
- REQ in FETCH_A/FETCH_B, or in HOLD without ACK, is ignored (not queued).
- RA_A == RA_B is legal; both operands read the same entry, with forwarding applied independently per fetch cycle.
- Writes during HOLD to an address already fetched do not alter OPA/OPB; they are snapshot values.
- ACK outside HOLD is ignored.
- Address wrap: addresses are AW bits; no out-of-range case when DEPTH = 2^AW.
- Reset mid-fetch or mid-HOLD: immediate return to reset values. No partial operand survives.

Test Plan:
- Reset/idle: CLR=0 for 2 cycles, then release. Expect OPA=OPB=0, VALID=0, BUSY=0. REQ=1 with RA_A=0, RA_B=0 yields OPA=OPB=0, VALID=1 after 3 edges.
- Basic fetch: write bank[1]=0x0A, bank[2]=0x01, then REQ with RA_A=1, RA_B=2. Expect VALID after edge k+2, OPA=0x0A, OPB=0x01. Hold ACK=0 for 5 cycles: values stable. ACK=1 returns to IDLE, VALID=0.
- Forwarding: bank[3]=0x11. REQ with RA_A=3, RA_B=3. In the FETCH_A cycle, drive En=1, WA=3, D=0x55. Expect OPA=0x55, OPB=0x55 (B reads the stored value).
- Snapshot: in HOLD with OPA=0x0A, write bank[1]=0xFF. Expect OPA stays 0x0A until ACK. A subsequent fetch of RA_A=1 yields 0xFF.
- Back-to-back and ignored REQ: in HOLD, ACK=1 and REQ=1 with RA_A=2, RA_B=1. Expect FETCH_A next with no IDLE gap and new operands 0x01/0xFF. REQ pulses in FETCH_B are ignored: exactly one VALID window per accepted request.
- Async reset mid-operation: assert CLR=0 mid-cycle in FETCH_B. Expect immediately (no clock edge) VALID=0, BUSY=0, OPA=OPB=0, bank cleared. A fetch after release returns 0x00.
